// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the ROB completion port among N_REQ functional units.
// Ports: clk, rst_n (async low); req_valid/req_ready/req_index/req_value per
// requester; rob_head (age mode only); flush; cdb_ready from the ROB;
// registered cdb_valid/cdb_index/cdb_value and grant_id (debug).
// Macro CDB_AGE_PRIO_EN: oldest-first grant relative to rob_head.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*IDX_W-1:0]  req_index,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  input  logic [IDX_W-1:0]        rob_head,
  input  logic                    flush,
  input  logic                    cdb_ready,
  output logic                    cdb_valid,
  output logic [IDX_W-1:0]        cdb_index,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [2:0]              grant_id
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic             free;
  logic             found;
  logic             fire;
  logic [2:0]       sel;

  assign free = !cdb_valid || cdb_ready;

`ifdef CDB_AGE_PRIO_EN
  // Smallest distance from the ROB head wins; strict compare keeps
  // ties on the lowest requester number.
  always_comb begin
    logic [IDX_W-1:0] age;
    logic [IDX_W-1:0] best;
    found = 1'b0;
    sel   = '0;
    age   = '0;
    best  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = req_index[i*IDX_W +: IDX_W] - rob_head;
      if (req_valid[i] && (!found || age < best)) begin
        found = 1'b1;
        best  = age;
        sel   = 3'(i);
      end
    end
  end

  logic unused_rr;
  assign unused_rr = ^rr_ptr;
`else
  // First valid requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        sel   = 3'(j);
      end
    end
  end

  logic unused_head;
  assign unused_head = ^rob_head;
`endif

  assign req_ready = (found && free && !flush && rst_n)
                   ? (N_REQ'(1) << sel) : '0;
  assign fire = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_index <= '0;
      cdb_value <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      // Pending entry is dropped even under backpressure.
      cdb_valid <= 1'b0;
    end else if (fire) begin
      cdb_valid <= 1'b1;
      cdb_index <= req_index[sel*IDX_W +: IDX_W];
      cdb_value <= req_value[sel*DATA_W +: DATA_W];
      grant_id  <= sel;
      rr_ptr    <= (sel == 3'(N_REQ-1)) ? '0 : PTR_W'(sel + 3'd1);
    end else if (cdb_ready) begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the ROB's single completion port (finish_instruction / index / value) among N_REQ functional units.
- Each functional unit presents a finished result (ROB index + 16-bit value) through a valid/ready handshake.
- The arbiter grants one requester per cycle and drives a registered common-data-bus (CDB) output straight into the ROB finish port.
- Sits between the execution units and the ROB.

Parameters:
N_REQ, 4, number of requesting functional units (2..8)
IDX_W, 4, ROB index width (ROB depth 16)
DATA_W, 16, result value width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  requester i holds a finished result
req_ready  output  N_REQ  requester i's result is accepted this cycle
req_index  input  N_REQ*IDX_W  ROB index of requester i, slice [i*IDX_W +: IDX_W]
req_value  input  N_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
rob_head  input  IDX_W  current ROB head (used only with CDB_AGE_PRIO_EN)
flush  input  1  pipeline flush (mispredict/exception)
cdb_ready  input  1  ROB accepts CDB this cycle (tie 1 for an always-accepting ROB)
cdb_valid  output  1  drives ROB finish_instruction
cdb_index  output  IDX_W  drives ROB index
cdb_value  output  DATA_W  drives ROB value
grant_id  output  3  requester number of the current CDB entry (debug)

Behaviour:
- Reset (async, rst_n=0): cdb_valid=0, cdb_index=0, cdb_value=0, grant_id=0, rr_ptr=0. req_ready is combinational and is 0 while in reset.
- Output register is free when cdb_valid=0 or cdb_ready=1.
- Grant (combinational):
  - When the output register is free and flush=0, select exactly one i with req_valid[i]=1.
  - Round-robin: search from rr_ptr upward, modulo N_REQ.
  - req_ready[i]=1 only for the selected i; all other bits are 0.
- Transfer (req_valid[i] & req_ready[i]):
  - Next edge: cdb_valid=1, cdb_index=req_index[i], cdb_value=req_value[i], grant_id=i.
  - rr_ptr=(i+1) mod N_REQ.
  - Latency: request accepted in cycle t appears on the CDB in cycle t+1.
- Hold: when cdb_valid=1 and cdb_ready=0, all CDB outputs are stable, req_ready=0 for every requester, rr_ptr unchanged.
- Drain: when cdb_valid=1, cdb_ready=1 and no request is valid, cdb_valid goes to 0 next edge; index/value hold their last values.
- Back-to-back: with cdb_ready=1, one result per cycle sustained; no bubble between consecutive grants.
- Flush:
  - req_ready=0 in the flush cycle.
  - Next edge: cdb_valid=0, and the pending CDB entry is dropped even if cdb_ready=0.
  - rr_ptr is retained.
  - Requesters are responsible for dropping their own results.
- No requests: req_ready=0 for all bits, rr_ptr unchanged.
- Fairness: a requester holding req_valid=1 is granted within N_REQ transfers.
- Requester obligation (assertion in bench): once req_valid=1, req_valid/index/value stay stable until accepted, unless flush=1.
- Reset mid-transfer: immediately returns all state to reset values; no partial CDB entry is emitted.
- rr_ptr width is clog2(N_REQ); wrap from N_REQ-1 to 0 explicitly (N_REQ need not be a power of 2).

Optional Feature:
- Macro CDB_AGE_PRIO_EN.
- Defined:
  - Grant the valid requester with the smallest age, where age=(req_index - rob_head) mod 2^IDX_W (oldest instruction first, helping head retirement).
  - Ties go to the lowest requester number.
  - rr_ptr is still updated but not used.
- Undefined: pure round-robin as above; rob_head is ignored (no logic depends on it).

Test Plan:
- Reset: assert rst_n=0 mid-run with cdb_valid=1 -> cdb_valid=0, rr_ptr=0 immediately; after release with req_valid=4'b0001, index=3, value=16'hBEEF -> req_ready=4'b0001, next cycle cdb_valid=1, cdb_index=3, cdb_value=16'hBEEF, grant_id=0.
- Round-robin: req_valid=4'b1111 held for 8 cycles, cdb_ready=1 -> grant_id sequence 0,1,2,3,0,1,2,3, one transfer per cycle.
- Backpressure: cdb_ready=0 for 3 cycles with CDB holding index 5 -> outputs stable, req_ready=0; cdb_ready=1 -> next waiting requester appears the following cycle.
- Flush: flush=1 while cdb_valid=1 and cdb_ready=0 -> req_ready=0 that cycle, cdb_valid=0 next cycle, next grant resumes from retained rr_ptr.
- Wrap/sparse: rr_ptr=3 with req_valid=4'b0110 -> grant 1, then rr_ptr=2 -> grant 2.
- CDB_AGE_PRIO_EN: rob_head=14, req0 index=2, req1 index=15, req2 index=14 -> grant order 2,1,0; without the macro and rr_ptr=0 -> 0,1,2.
